// File: rtl/norm_shift_unit_if.sv
// Handshake bundle for the normalizer: operand request side and result side.
// Both sides use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; the producer holds valid and its payload
// stable until that edge, and ready may depend on state but never on valid.
interface norm_shift_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_norm;
  logic [5:0]  out_shamt;
  logic        out_zero;

  // Requester / result consumer (e.g. issue stage)
  modport master (
    output in_valid, a, signed_mode, out_ready,
    input  in_ready, out_valid, out_norm, out_shamt, out_zero
  );

  // The normalizer itself
  modport slave (
    input  in_valid, a, signed_mode, out_ready,
    output in_ready, out_valid, out_norm, out_shamt, out_zero
  );
endinterface

// File: rtl/norm_shift_unit.sv
// Multi-cycle normalizer: finds the left-shift amount that normalizes a
// 32-bit operand (leading zeros, or redundant sign bits in signed mode)
// using a 5-step binary search (16/8/4/2/1), one step per clock.
module norm_shift_unit (
  input  logic              clk,
  input  logic              rst,
  norm_shift_unit_if.slave  bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] working;
  logic [5:0]  count;
  logic [4:0]  step;        // one-hot search step: 16,8,4,2,1
  logic        mode;
  logic        zero;

  logic        accept;
  logic        release_res;
  logic        last_step;

  logic        hit;
  logic        u_hit;
  logic        s_hit;
  logic [5:0]  step_amt;
  logic [31:0] work_next;
  logic [5:0]  count_next;

  logic [31:0] norm_q;
  logic [5:0]  shamt_q;
  logic        zero_q;

  assign accept      = bus.in_valid && (state == S_IDLE);
  assign release_res = bus.out_ready && (state == S_DONE);
  assign last_step   = step[0];
  assign dbg_state   = state;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (accept)      state_next = S_RUN;
      S_RUN:   if (last_step)   state_next = S_DONE;
      S_DONE:  if (release_res) state_next = S_IDLE;
      default:                  state_next = S_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      S_IDLE:  bus.in_ready  = 1'b1;
      S_DONE:  bus.out_valid = 1'b1;
      default: ;
    endcase
  end

  // One search step: test the top k (unsigned) or k+1 (signed) bits and
  // shift them out when they carry no information
  always_comb begin
    u_hit    = 1'b0;
    s_hit    = 1'b0;
    step_amt = 6'd0;
    unique case (step)
      5'b10000: begin
        step_amt = 6'd16;
        u_hit    = (working[31:16] == 16'h0000);
        s_hit    = (working[31:15] == 17'h00000) || (working[31:15] == 17'h1ffff);
      end
      5'b01000: begin
        step_amt = 6'd8;
        u_hit    = (working[31:24] == 8'h00);
        s_hit    = (working[31:23] == 9'h000) || (working[31:23] == 9'h1ff);
      end
      5'b00100: begin
        step_amt = 6'd4;
        u_hit    = (working[31:28] == 4'h0);
        s_hit    = (working[31:27] == 5'h00) || (working[31:27] == 5'h1f);
      end
      5'b00010: begin
        step_amt = 6'd2;
        u_hit    = (working[31:30] == 2'b00);
        s_hit    = (working[31:29] == 3'b000) || (working[31:29] == 3'b111);
      end
      5'b00001: begin
        step_amt = 6'd1;
        u_hit    = (working[31] == 1'b0);
        s_hit    = (working[31] == working[30]);
      end
      default: ;
    endcase
    hit        = mode ? s_hit : u_hit;
    work_next  = hit ? (working << step_amt) : working;
    count_next = hit ? (count + step_amt) : count;
  end

  // Working datapath: capture on accept, one search step per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      working <= 32'h0;
      count   <= 6'd0;
      step    <= 5'b00000;
      mode    <= 1'b0;
      zero    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            working <= bus.a;
            mode    <= bus.signed_mode;
            zero    <= (bus.a == 32'h0);
            count   <= 6'd0;
            step    <= 5'b10000;
          end
        end
        S_RUN: begin
          working <= work_next;
          count   <= count_next;
          step    <= step >> 1;
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded on the final step, held through DONE and after.
  // The unsigned search saturates at 31 for a zero operand, so the zero flag
  // promotes it to the full width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      norm_q  <= 32'h0;
      shamt_q <= 6'd0;
      zero_q  <= 1'b0;
    end else if ((state == S_RUN) && last_step) begin
      norm_q  <= work_next;
      shamt_q <= (zero && !mode) ? 6'd32 : count_next;
      zero_q  <= zero;
    end
  end

  assign bus.out_norm  = norm_q;
  assign bus.out_shamt = shamt_q;
  assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_norm_shift_unit.sv
// Directed bench for norm_shift_unit with a scoreboard of expected results.
module tb_norm_shift_unit;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         errors;
  int         checks;

  // Expected entry: {norm[31:0], shamt[5:0], zero}
  logic [38:0] exp_q[$];

  norm_shift_unit_if bus ();

  norm_shift_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: straightforward bit-walking count, independent of the
  // binary-search structure of the design
  function automatic logic [38:0] model(input logic [31:0] v, input logic sm);
    int         n;
    logic [5:0] sh;
    logic [31:0] nv;
    n = 0;
    if (!sm) begin
      if (v == 32'h0) n = 32;
      else while (v[31-n] == 1'b0) n++;
    end else begin
      while (n < 31 && v[30-n] == v[31]) n++;
    end
    sh = n[5:0];
    nv = (n == 32) ? 32'h0 : (v << n);
    return {nv, sh, (v == 32'h0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Offer one operand; returns #1 after the acceptance edge
  task automatic start_op(input logic [31:0] v, input logic sm);
    @(negedge clk);
    chk("in_ready_idle", {31'b0, bus.in_ready}, 32'd1);
    bus.a           = v;
    bus.signed_mode = sm;
    bus.in_valid    = 1'b1;
    exp_q.push_back(model(v, sm));
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.a           = $urandom;
    bus.signed_mode = 1'($urandom_range(0, 1));
  endtask

  // Count edges until out_valid (bounded); checks the 5-cycle latency
  task automatic wait_valid();
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, 32'd5);
  endtask

  // Consume the pending result and compare it against the scoreboard
  task automatic take_result();
    logic [38:0] e;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_done", {31'b0, bus.out_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk("out_norm",  bus.out_norm, e[38:7]);
    chk("out_shamt", {26'b0, bus.out_shamt}, {26'b0, e[6:1]});
    chk("out_zero",  {31'b0, bus.out_zero}, {31'b0, e[0]});
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("out_valid_after", {31'b0, bus.out_valid}, 32'd0);
    chk("in_ready_after",  {31'b0, bus.in_ready}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] v, input logic sm);
    start_op(v, sm);
    wait_valid();
    take_result();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  {31'b0, bus.in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_out_norm"},  bus.out_norm, 32'h0);
    chk({tag, "_out_shamt"}, {26'b0, bus.out_shamt}, 32'd0);
    chk({tag, "_out_zero"},  {31'b0, bus.out_zero}, 32'd0);
    chk({tag, "_state"},     {30'b0, dbg_state}, 32'd0);
  endtask

  initial begin
    logic [38:0] e;
    int          seen;
    errors = 0;
    checks = 0;
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.a           = 32'h0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Directed corner cases
    run_op(32'h0000_0001, 1'b0);
    run_op(32'h0000_0000, 1'b0);
    run_op(32'h0000_0000, 1'b1);
    run_op(32'hFFFF_FFF0, 1'b1);
    run_op(32'h0000_1000, 1'b1);
    run_op(32'hFFFF_FFFF, 1'b1);
    run_op(32'h8000_0000, 1'b0);
    run_op(32'h8000_0000, 1'b1);
    run_op(32'h7FFF_FFFF, 1'b1);

    // out_ready held high ahead of time: consumed on the first DONE cycle
    bus.out_ready = 1'b1;
    run_op(32'h0003_0000, 1'b0);

    // Random operands in both modes
    for (int i = 0; i < 8; i++) begin
      logic [31:0] r;
      r = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = ~r;
      run_op(r, 1'($urandom_range(0, 1)));
    end

    // Backpressure: out_ready low in DONE while in_valid high and a changing
    start_op(32'h0000_0100, 1'b0);
    wait_valid();
    e = exp_q[0];
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.a           = $urandom;
      bus.signed_mode = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_in_ready",  {31'b0, bus.in_ready}, 32'd0);
      chk("bp_norm",      bus.out_norm, e[38:7]);
      chk("bp_shamt",     {26'b0, bus.out_shamt}, {26'b0, e[6:1]});
      @(posedge clk);
      #1;
    end
    take_result();
    @(negedge clk);
    chk("bp_no_capture", {30'b0, dbg_state}, 32'd0);

    // Reset in the third RUN cycle aborts the operation
    start_op(32'h0000_ABCD, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_vals("abort");
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("abort_no_valid", seen, 32'd0);
    run_op(32'h00F0_0000, 1'b0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/norm_shift_unit.md
# norm_shift_unit

Multi-cycle normalizer for the CPU datapath: the inverse of the left/arithmetic-right shift units. The shift units take a value and a shift amount. This block takes a value and derives the shift amount that normalizes it, returning that amount and the shifted result. In unsigned mode it counts leading zeros. In signed mode it counts redundant sign bits. It uses a 5-step binary search (16/8/4/2/1), one step per clock, and has valid/ready handshakes on both sides so it can sit behind the ALU issue stage.

## Interface
- No parameters; width fixed at 32, shift amount 6 bits.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand offered.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  32  operand, sampled on acceptance.
- signed_mode  in  1  0 = leading-zero normalize; 1 = redundant-sign-bit normalize; sampled on acceptance.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_norm  out  32  a << out_shamt.
- out_shamt  out  6  shift amount, 0..32.
- out_zero  out  1  sampled a == 0.

## Operation
- States:
  - IDLE: in_ready=1; in_valid & in_ready captures a, signed_mode, zero flag, clears working count, goes to RUN with step=16.
  - RUN: 5 cycles, step 16,8,4,2,1; after step 1 go to DONE.
  - DONE: out_valid=1; out_valid & out_ready returns to IDLE.
- Unsigned step k: if working[31:32-k] all zero, shift working left k and add k to count; else hold.
- Signed step k: if working[31:31-k] (k+1 bits) all equal, shift working left k and add k; else hold.
- Result rules:
  - Unsigned, a==0: out_shamt=32, out_norm=0, out_zero=1. The search yields 31; the zero flag overrides it to 32.
  - Unsigned, nonzero: out_shamt=clz(a) in 0..31, out_norm[31]=1.
  - Signed, nonzero, a != 0xFFFFFFFF: out_norm[31] != out_norm[30].
  - Signed, a==0 or a==0xFFFFFFFF: out_shamt=31; out_norm = 0x00000000 or 0x80000000 respectively.
- out_norm, out_shamt, out_zero are registered. They are loaded on the RUN->DONE transition and held stable while out_valid=1.
- in_valid is ignored outside IDLE; there is no queueing and no overlap of operations.
- a and signed_mode may change freely after acceptance.

## Timing
- Reset values:
  - state IDLE
  - in_ready=1
  - out_valid=0
  - out_norm=0, out_shamt=0, out_zero=0
  - working register and count cleared
- Latency: acceptance at edge T; steps at edges T+1..T+5; out_valid high from edge T+5.
- The block returns to IDLE at the first edge where out_valid & out_ready. in_ready is high in the following cycle, so throughput is one result per 7 cycles minimum.
- out_ready may be held high in advance; the result is consumed on the first DONE cycle.
- Reset asserted mid-RUN or in DONE aborts immediately to reset values. No out_valid follows.

## Test plan
- Unsigned a=0x00000001: out_shamt=31, out_norm=0x80000000, out_zero=0, out_valid exactly 5 cycles after acceptance.
- Unsigned a=0x00000000: out_shamt=32, out_norm=0, out_zero=1. Same input in signed mode: out_shamt=31, out_norm=0, out_zero=1.
- Signed a=0xFFFFFFF0: out_shamt=27, out_norm=0x80000000. Signed a=0x00001000: out_shamt=18, out_norm=0x40000000. Signed a=0xFFFFFFFF: out_shamt=31, out_norm=0x80000000.
- a=0x80000000, both modes: out_shamt=0, out_norm=0x80000000.
- Backpressure: out_ready low for 3 cycles in DONE, with in_valid high and a changing. Outputs stay stable, in_ready=0, no new capture. Raise out_ready: one transfer, then in_ready=1 the next cycle.
- Assert rst at the 3rd RUN cycle: all outputs return to reset values asynchronously. After release, a fresh a=0x00F00000 (unsigned) gives out_shamt=8, out_norm=0xF0000000.
